spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter N, default 2, number of requesters.
REQ-002 SHALL have parameter S, default 2, number of slave selects; SW = max(1, clog2(S)).
REQ-003 SHALL have parameter SETUP_CYC, default 4, cycles ss_n held low before first byte.
REQ-004 SHALL have parameter HOLD_CYC, default 4, cycles ss_n held low after last byte.
REQ-005 SHALL have parameter TIMEOUT, default 65535, per-byte watchdog limit in cycles.
REQ-006 SHALL have ports: clk in 1, system clock; reset in 1, synchronous active-low reset.
REQ-007 SHALL have ports: req in N, request; req_ss in N*SW, slave index; req_len in N*4, byte count minus 1; tx_data in N*8, next byte to send.
REQ-008 SHALL have ports: gnt out N, one-hot grant; tx_ack out N, byte consumed; rx_data out 8, received byte; rx_valid out N; done out N; err out N.
REQ-009 SHALL have ports: spi_start out 1; spi_din out 8; spi_dout in 8; spi_ready in 1; spi_done_tick in 1; spi_ss_n out S.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, START, WAIT, HOLD, with only the transitions in REQ-011 to REQ-016.
REQ-011 IDLE: SHALL sample req only here; if any bit set, grant the first set index at or after rr_ptr (wrapping); register gnt, req_ss and req_len of the winner; go to SETUP.
REQ-012 SETUP: SHALL drive spi_ss_n[sel] low (all high if sel >= S); after SETUP_CYC cycles go to START.
REQ-013 START: SHALL wait while spi_ready=0; when spi_ready=1, pulse spi_start for 1 cycle with spi_din = tx_data of the granted requester and pulse tx_ack[gnt] in the same cycle; go to WAIT.
REQ-014 WAIT: on spi_done_tick, SHALL register spi_dout to rx_data and pulse rx_valid[gnt] the following cycle; if the byte counter is 0, go to HOLD; otherwise decrement it and go to START.
REQ-015 HOLD: SHALL keep ss low HOLD_CYC cycles, then deassert all ss_n, pulse done[gnt] for 1 cycle, set rr_ptr = (gnt+1) mod N, clear gnt, and go to IDLE.
REQ-016 SHALL spend at least 1 cycle in IDLE between transactions, so ss_n is high for at least 1 cycle.
REQ-017 SHALL ignore req deassertion mid-transaction; the transaction completes (req_len+1 bytes).
REQ-018 SHALL count bytes with a 4-bit down counter; req_len=15 yields 16 bytes, with no wrap beyond 0.
REQ-019 SHALL keep gnt, tx_ack, rx_valid, done and err one-hot or zero at all times.

Reset
REQ-020 On reset=0 at a clk edge, SHALL force: state IDLE, gnt 0, rr_ptr 0, spi_ss_n all 1, spi_start 0, spi_din 0, tx_ack/rx_valid/done/err 0, rx_data 0, counters 0.
REQ-021 Reset mid-transaction SHALL release ss_n on the next edge, with no done or err pulse.

Configuration
REQ-022 With SPI_ARB_TIMEOUT_EN defined, WAIT SHALL count cycles; on reaching TIMEOUT without spi_done_tick, it SHALL deassert ss_n, pulse err[gnt] and done[gnt] together, advance rr_ptr, and go to IDLE.
REQ-023 Without SPI_ARB_TIMEOUT_EN, err SHALL be tied 0 and WAIT SHALL wait indefinitely; no timeout counter is synthesized.

Structure
REQ-024 Package spi_arb_pkg SHALL hold the FSM state enum, the SW width function and default parameter constants.
REQ-025 Sub-module rr_arbiter SHALL implement the round-robin pick (inputs req and rr_ptr, output one-hot grant), and SHALL be purely combinational.

Verification
REQ-026 Single request: req[0]=1, req_len=0, req_ss=1, tx_data=0xA5, loopback spi_dout=0x3C -> spi_ss_n=2'b01 for SETUP+HOLD+byte, one spi_start with din 0xA5, rx_data=0x3C with rx_valid[0], then done[0].
REQ-027 Multi-byte: req_len=15 -> exactly 16 tx_ack and 16 rx_valid pulses, one ss_n low window, one done.
REQ-028 Contention: req=2'b11 held continuously -> grants alternate 0,1,0,1; ss_n goes high at least 1 cycle between each.
REQ-029 Backpressure: spi_ready=0 for 20 cycles in START -> no spi_start until ready; then exactly one start.
REQ-030 Reset mid-WAIT: reset=0 one cycle -> spi_ss_n all 1 next cycle, gnt=0, no done.
REQ-031 Timeout (macro on, TIMEOUT=100): spi_done_tick never fires -> err[gnt] and done[gnt] pulse 100 cycles after start, ss_n released, next requester served.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI bus arbiter: FSM state encoding,
// select-width helper and default parameter values.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int DEF_N         = 2;
  localparam int DEF_S         = 2;
  localparam int DEF_SETUP_CYC = 4;
  localparam int DEF_HOLD_CYC  = 4;
  localparam int DEF_TIMEOUT   = 65535;

  // Index width for a set of s items, never narrower than one bit.
  function automatic int sw_width(input int s);
    return (s <= 1) ? 1 : $clog2(s);
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester-side bus of the SPI arbiter: requests, per-requester byte feed,
// grant and per-byte/per-transaction status pulses.
interface spi_arbiter_if #(
  parameter int N  = 2,
  parameter int SW = 1
);
  logic [N-1:0]    req;
  logic [N*SW-1:0] req_ss;
  logic [N*4-1:0]  req_len;
  logic [N*8-1:0]  tx_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    tx_ack;
  logic [7:0]      rx_data;
  logic [N-1:0]    rx_valid;
  logic [N-1:0]    done;
  logic [N-1:0]    err;

  modport master (
    output req, req_ss, req_len, tx_data,
    input  gnt, tx_ack, rx_data, rx_valid, done, err
  );

  modport slave (
    input  req, req_ss, req_len, tx_data,
    output gnt, tx_ack, rx_data, rx_valid, done, err
  );
endinterface

// File: rtl/spi_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// wrapping around; one-hot result, all zero when nothing is requested.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  grant
);
  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI byte engine among N requesters with round-robin fairness.
// Define SPI_ARB_TIMEOUT_EN to add a per-byte watchdog that aborts with err.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int S         = DEF_S,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  spi_arbiter_if.slave  bus,
  output logic          spi_start,
  output logic [7:0]    spi_din,
  input  logic [7:0]    spi_dout,
  input  logic          spi_ready,
  input  logic          spi_done_tick,
  output logic [S-1:0]  spi_ss_n
);
  localparam int SW = sw_width(S);
  localparam int PW = sw_width(N);

  state_t        state_reg;
  logic [N-1:0]  gnt_reg, tx_ack_reg, rx_valid_reg, done_reg;
  logic [PW-1:0] gidx_reg, rr_ptr_reg, next_ptr, win_idx;
  logic [3:0]    cnt_reg;
  logic [15:0]   tmr_reg;
  logic [S-1:0]  ss_n_reg, win_ss_n;
  logic          spi_start_reg;
  logic [7:0]    spi_din_reg, rx_data_reg;
  logic [N-1:0]  grant;
  logic [SW-1:0] win_ss;

  rr_arbiter #(.N(N), .PW(PW)) u_rr (
    .req    (bus.req),
    .rr_ptr (rr_ptr_reg),
    .grant  (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

  assign win_ss   = bus.req_ss[win_idx*SW +: SW];
  assign next_ptr = (int'(gidx_reg) == N - 1) ? '0 : gidx_reg + PW'(1);

  // Out-of-range select indices leave every line high.
  for (genvar gi = 0; gi < S; gi++) begin : g_ss_dec
    assign win_ss_n[gi] = (int'(win_ss) != gi);
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_reg;
  logic [N-1:0]   err_reg;
  assign bus.err = err_reg;
`else
  assign bus.err = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      gidx_reg      <= '0;
      rr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      tmr_reg       <= '0;
      ss_n_reg      <= '1;
      spi_start_reg <= 1'b0;
      spi_din_reg   <= '0;
      rx_data_reg   <= '0;
      tx_ack_reg    <= '0;
      rx_valid_reg  <= '0;
      done_reg      <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_reg        <= '0;
      err_reg       <= '0;
`endif
    end else begin
      spi_start_reg <= 1'b0;
      tx_ack_reg    <= '0;
      rx_valid_reg  <= '0;
      done_reg      <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_reg       <= '0;
`endif
      case (state_reg)
        IDLE: if (|bus.req) begin
          gnt_reg   <= grant;
          gidx_reg  <= win_idx;
          cnt_reg   <= bus.req_len[win_idx*4 +: 4];
          ss_n_reg  <= win_ss_n;
          tmr_reg   <= '0;
          state_reg <= SETUP;
        end
        SETUP: if (int'(tmr_reg) + 1 >= SETUP_CYC) begin
          tmr_reg   <= '0;
          state_reg <= START;
        end else begin
          tmr_reg <= tmr_reg + 16'd1;
        end
        START: if (spi_ready) begin
          spi_start_reg <= 1'b1;
          spi_din_reg   <= bus.tx_data[gidx_reg*8 +: 8];
          tx_ack_reg    <= gnt_reg;
`ifdef SPI_ARB_TIMEOUT_EN
          wd_reg        <= '0;
`endif
          state_reg     <= WAIT;
        end
        WAIT: if (spi_done_tick) begin
          rx_data_reg  <= spi_dout;
          rx_valid_reg <= gnt_reg;
          if (cnt_reg == 4'd0) begin
            tmr_reg   <= '0;
            state_reg <= HOLD;
          end else begin
            cnt_reg   <= cnt_reg - 4'd1;
            state_reg <= START;
          end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_reg == WDW'(TIMEOUT - 1)) begin
          ss_n_reg   <= '1;
          err_reg    <= gnt_reg;
          done_reg   <= gnt_reg;
          rr_ptr_reg <= next_ptr;
          gnt_reg    <= '0;
          state_reg  <= IDLE;
        end else begin
          wd_reg <= wd_reg + WDW'(1);
        end
`endif
        HOLD: if (int'(tmr_reg) + 1 >= HOLD_CYC) begin
          ss_n_reg   <= '1;
          done_reg   <= gnt_reg;
          rr_ptr_reg <= next_ptr;
          gnt_reg    <= '0;
          state_reg  <= IDLE;
        end else begin
          tmr_reg <= tmr_reg + 16'd1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.tx_ack   = tx_ack_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.done     = done_reg;
  assign spi_start    = spi_start_reg;
  assign spi_din      = spi_din_reg;
  assign spi_ss_n     = ss_n_reg;
endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: a transaction-level reference model
// predicts every output each cycle while directed and random traffic runs.
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int N = 2, S = 2, SW = sw_width(S);
  localparam int SETUP_CYC = 4, HOLD_CYC = 4, TIMEOUT = 100;
  localparam int MD_IDLE = 0, MD_SETUP = 1, MD_READY = 2, MD_FLIGHT = 3, MD_HOLD = 4;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic spi_start, spi_ready, spi_done_tick;
  logic [7:0] spi_din, spi_dout;
  logic [S-1:0] spi_ss_n;

  spi_arbiter_if #(.N(N), .SW(SW)) bus_if ();

  spi_arbiter #(.N(N), .S(S), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .spi_start(spi_start), .spi_din(spi_din),
    .spi_dout(spi_dout), .spi_ready(spi_ready), .spi_done_tick(spi_done_tick), .spi_ss_n(spi_ss_n)
  );

  int checks = 0, errors = 0, cyc = 0;
  // SPI engine stand-in and requester byte feed
  bit sl_busy = 0, mute = 0, bp_hold = 0;
  int sl_lat = 0;
  logic [7:0] sl_din = 8'h00;
  int seq [N];
  logic [7:0] base [N];
  // reference model
  bit armed = 0;
  int m_mode = MD_IDLE, m_owner = 0, m_bytes = 0, m_phase = 0, m_wd = 0, m_ptr = 0;
  logic [N-1:0] e_gnt, e_ack, e_rxv, e_done, e_err;
  logic e_start;
  logic [7:0] e_din, e_rxd;
  logic [S-1:0] e_ssn;
  // event monitor
  int n_start = 0, n_ack = 0, n_rxv = 0, n_done = 0, n_err = 0, n_grant = 0, n_win = 0;
  int start_cyc = 0, err_cyc = 0, hi_run = 100, min_gap = 1000;
  logic [7:0] cap_din, cap_rxd;
  logic [N-1:0] cap_rxv, cap_done, cap_err, cap_err_done, cap_gnt, prev_gnt = '0;
  logic [S-1:0] cap_done_ssn, cap_gnt_ssn, prev_ssn = '1;
  int glog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (bus_if.tx_ack[i] === 1'b1) seq[i]++;
      bus_if.tx_data[i*8 +: 8] = base[i] + 8'(seq[i]);
    end
    spi_done_tick = 1'b0;
    if (reset !== 1'b1) sl_busy = 0;
    else if (sl_busy) begin
      sl_lat--;
      if (sl_lat == 0) begin
        sl_busy = 0;
        if (!mute) begin
          spi_done_tick = 1'b1;
          spi_dout = sl_din ^ 8'h99;
        end
      end
    end else if (spi_start === 1'b1) begin
      sl_busy = 1;
      sl_din = spi_din;
      sl_lat = $urandom_range(1, 4);
    end
    spi_ready = !sl_busy && !bp_hold;
  endtask

  function automatic int count_of(input int kind);
    case (kind)
      0: return n_start;
      1: return n_rxv;
      2: return n_done;
      3: return n_err;
      default: return n_grant;
    endcase
  endfunction

  task automatic wait_until(input int kind, input int target, input int budget);
    int b = 0;
    while (count_of(kind) < target && b < budget) begin
      step();
      b++;
    end
    chk($sformatf("wait_event%0d", kind), count_of(kind) >= target, 1);
  endtask

  task automatic finish_txn();
    e_done[m_owner] = 1'b1;
    e_ssn = '1;
    e_gnt = '0;
    m_ptr = (m_owner + 1) % N;
    m_mode = MD_IDLE;
  endtask

  task automatic model_step();
    int w, ss;
    if (reset !== 1'b1) begin
      e_gnt = '0; e_ssn = '1; e_start = 1'b0; e_din = '0; e_ack = '0;
      e_rxd = '0; e_rxv = '0; e_done = '0; e_err = '0;
      m_mode = MD_IDLE; m_ptr = 0; armed = 1;
      return;
    end
    e_start = 1'b0; e_ack = '0; e_rxv = '0; e_done = '0; e_err = '0;
    case (m_mode)
      MD_IDLE: if (bus_if.req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && bus_if.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_owner = w;
        e_gnt = '0;
        e_gnt[w] = 1'b1;
        ss = int'(bus_if.req_ss[w*SW +: SW]);
        e_ssn = '1;
        if (ss < S) e_ssn[ss] = 1'b0;
        m_bytes = int'(bus_if.req_len[w*4 +: 4]) + 1;
        m_phase = SETUP_CYC;
        m_mode = MD_SETUP;
      end
      MD_SETUP: begin
        m_phase--;
        if (m_phase <= 0) m_mode = MD_READY;
      end
      MD_READY: if (spi_ready === 1'b1) begin
        e_start = 1'b1;
        e_din = bus_if.tx_data[m_owner*8 +: 8];
        e_ack[m_owner] = 1'b1;
        m_wd = 0;
        m_mode = MD_FLIGHT;
      end
      MD_FLIGHT: begin
        if (spi_done_tick === 1'b1) begin
          e_rxv[m_owner] = 1'b1;
          e_rxd = spi_dout;
          m_bytes--;
          if (m_bytes == 0) begin
            m_phase = HOLD_CYC;
            m_mode = MD_HOLD;
          end else m_mode = MD_READY;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else begin
          m_wd++;
          if (m_wd == TIMEOUT) begin
            e_err[m_owner] = 1'b1;
            finish_txn();
          end
        end
`endif
      end
      default: begin
        m_phase--;
        if (m_phase <= 0) finish_txn();
      end
    endcase
  endtask

  task automatic monitor();
    if (spi_start === 1'b1) begin n_start++; cap_din = spi_din; start_cyc = cyc; end
    if (|bus_if.tx_ack) n_ack++;
    if (|bus_if.rx_valid) begin n_rxv++; cap_rxd = bus_if.rx_data; cap_rxv = bus_if.rx_valid; end
    if (|bus_if.done) begin n_done++; cap_done = bus_if.done; cap_done_ssn = spi_ss_n; end
    if (|bus_if.err) begin n_err++; cap_err = bus_if.err; cap_err_done = bus_if.done; err_cyc = cyc; end
    if (bus_if.gnt != '0 && prev_gnt == '0) begin
      n_grant++;
      cap_gnt = bus_if.gnt;
      cap_gnt_ssn = spi_ss_n;
      glog.push_back(bus_if.gnt[1] ? 1 : 0);
    end
    if (spi_ss_n != '1 && spi_ss_n != prev_ssn) begin
      n_win++;
      if (prev_ssn == '1) begin
        if (hi_run < min_gap) min_gap = hi_run;
      end else min_gap = 0;
    end
    hi_run = (spi_ss_n == '1) ? hi_run + 1 : 0;
    prev_gnt = bus_if.gnt;
    prev_ssn = spi_ss_n;
  endtask

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("gnt", 32'(bus_if.gnt), 32'(e_gnt));
        chk("ss_n", 32'(spi_ss_n), 32'(e_ssn));
        chk("spi_start", 32'(spi_start), 32'(e_start));
        chk("spi_din", 32'(spi_din), 32'(e_din));
        chk("tx_ack", 32'(bus_if.tx_ack), 32'(e_ack));
        chk("rx_valid", 32'(bus_if.rx_valid), 32'(e_rxv));
        chk("rx_data", 32'(bus_if.rx_data), 32'(e_rxd));
        chk("done", 32'(bus_if.done), 32'(e_done));
        chk("err", 32'(bus_if.err), 32'(e_err));
        chk("onehot", {$onehot0(bus_if.gnt), $onehot0(bus_if.tx_ack), $onehot0(bus_if.rx_valid),
                       $onehot0(bus_if.done), $onehot0(bus_if.err)}, 32'h1f);
        if (reset === 1'b1) monitor();
      end
      model_step();
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, d0, w0, s0, eidx;
    bus_if.req = '0; bus_if.req_ss = '0; bus_if.req_len = '0; bus_if.tx_data = '0;
    spi_dout = '0; spi_ready = 1'b1; spi_done_tick = 1'b0;
    base[0] = 8'hA5; base[1] = 8'h40; seq[0] = 0; seq[1] = 0;
    repeat (3) step();
    chk("rst_gnt", 32'(bus_if.gnt), 0);
    chk("rst_ss_n", 32'(spi_ss_n), 32'h3);
    chk("rst_start", 32'(spi_start), 0);
    chk("rst_din", 32'(spi_din), 0);
    chk("rst_rx_data", 32'(bus_if.rx_data), 0);
    reset = 1'b1;
    step();

    // single byte to slave 1, loopback 0xA5 ^ 0x99 = 0x3C
    bus_if.req_ss = 2'b01; bus_if.req_len = 8'h00; bus_if.req = 2'b01;
    wait_until(4, n_grant + 1, 50);
    bus_if.req = 2'b00;
    chk("t1_gnt", 32'(cap_gnt), 32'h1);
    chk("t1_ss_n", 32'(cap_gnt_ssn), 32'h1);
    s0 = n_start;
    wait_until(0, n_start + 1, 50);
    chk("t1_din", 32'(cap_din), 32'hA5);
    wait_until(1, n_rxv + 1, 50);
    chk("t1_rx_data", 32'(cap_rxd), 32'h3C);
    chk("t1_rx_valid", 32'(cap_rxv), 32'h1);
    wait_until(2, n_done + 1, 50);
    chk("t1_done", 32'(cap_done), 32'h1);
    chk("t1_done_ss_n", 32'(cap_done_ssn), 32'h3);
    chk("t1_starts", n_start - s0, 1);

    // 16-byte transfer from requester 1
    a0 = n_ack; r0 = n_rxv; d0 = n_done; w0 = n_win;
    bus_if.req_ss = 2'b00; bus_if.req_len = 8'hF0; bus_if.req = 2'b10;
    wait_until(4, n_grant + 1, 50);
    bus_if.req = 2'b00;
    wait_until(2, d0 + 1, 1000);
    chk("t2_acks", n_ack - a0, 16);
    chk("t2_rx_valids", n_rxv - r0, 16);
    chk("t2_windows", n_win - w0, 1);
    chk("t2_dones", n_done - d0, 1);

    // contention: both requesting continuously
    glog.delete(); min_gap = 1000; d0 = n_done;
    bus_if.req_len = 8'h00; bus_if.req = 2'b11;
    wait_until(2, d0 + 4, 1000);
    bus_if.req = 2'b00;
    wait_until(2, d0 + 5, 200);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), glog[i], i % 2);
    chk("t3_ss_gap", min_gap >= 1, 1);

    // backpressure: engine not ready for well over 20 START cycles
    bp_hold = 1; d0 = n_done;
    bus_if.req = 2'b10;
    wait_until(4, n_grant + 1, 50);
    bus_if.req = 2'b00;
    s0 = n_start;
    repeat (SETUP_CYC + 22) step();
    chk("t4_no_start", n_start - s0, 0);
    bp_hold = 0;
    wait_until(2, d0 + 1, 100);
    chk("t4_one_start", n_start - s0, 1);

    // reset while a byte is in flight
    bus_if.req_len = 8'h03; bus_if.req = 2'b01;
    wait_until(4, n_grant + 1, 50);
    bus_if.req = 2'b00;
    wait_until(0, n_start + 1, 50);
    reset = 1'b0;
    d0 = n_done;
    step();
    chk("t5_ss_n", 32'(spi_ss_n), 32'h3);
    chk("t5_gnt", 32'(bus_if.gnt), 0);
    reset = 1'b1;
    repeat (30) step();
    chk("t5_no_done", n_done - d0, 0);

    // randomized traffic, model checks every cycle
    d0 = n_done;
    for (int it = 0; it < 2500; it++) begin
      step();
      if ($urandom_range(0, 7) == 0) bus_if.req = 2'($urandom_range(0, 3));
      bus_if.req_len = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      bus_if.req_ss = 2'($urandom_range(0, 3));
      bp_hold = ($urandom_range(0, 9) == 0);
    end
    bus_if.req = 2'b00; bp_hold = 0;
    repeat (200) step();
    chk("t6_progress", n_done > d0, 1);

`ifdef SPI_ARB_TIMEOUT_EN
    // silent engine: watchdog aborts, then the other requester is served
    mute = 1;
    bus_if.req_len = 8'h00; bus_if.req = 2'b11;
    wait_until(3, n_err + 1, 500);
    mute = 0;
    bus_if.req = 2'b00;
    eidx = cap_err[1] ? 1 : 0;
    chk("t7_err_with_done", 32'(cap_err_done), 32'(cap_err));
    chk("t7_latency", err_cyc - start_cyc, TIMEOUT);
    d0 = n_done;
    wait_until(2, d0 + 1, 200);
    chk("t7_next_served", glog[$], 1 - eidx);
`else
    eidx = 0;
`endif

    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
